// File: rtl/ppu_cpu_reg_if.sv
// CPU-side PPU register file ($2000-$2007): register decode, shared write toggle,
// buffered PPUDATA path, vblank/NMI. Optional NMI generation under PPU_NMI_EN.
module ppu_cpu_reg_if #(
  parameter int VRAM_AW = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_ready,
  input  logic        render,
  input  logic        vblank_start,
  input  logic        vblank_end,
  output logic [15:0] VRAM_addr,
  output logic        VRAM_WE,
  output logic [7:0]  VRAM_wdata,
  input  logic [7:0]  VRAM_rdata,
  output logic [4:0]  palette_addr,
  output logic        palette_WE,
  output logic [7:0]  palette_wdata,
  input  logic [7:0]  palette_rdata,
  output logic [7:0]  ppuctrl,
  output logic [7:0]  ppumask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic        nmi
);

  // state    | meaning
  // IDLE     | accepting CPU accesses
  // WAIT_BUS | PPUDATA pending, waiting for renderer to release VRAM
  // XFER     | address/strobe on the bus for one cycle
  // RD_CAP   | capture VRAM_rdata into the read buffer
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_BUS = 2'd1;
  localparam logic [1:0] S_XFER     = 2'd2;
  localparam logic [1:0] S_RD_CAP   = 2'd3;

  logic [1:0]         state;
  logic [VRAM_AW-1:0] v_addr;
  logic [VRAM_AW-1:0] v_inc;
  logic               toggle;
  logic               vblank;
  logic               vblank_nxt;
  logic               lat_rw;
  logic [7:0]         lat_data;
  logic [7:0]         rd_buf;
  logic               access;
  logic               status_rd;
  logic               is_pal;

  assign cpu_ready     = (state == S_IDLE);
  assign access        = cpu_ready & cpu_cs;
  assign status_rd     = access & cpu_rw & (cpu_addr == 3'd2);
  assign is_pal        = &v_addr[VRAM_AW-1:8];
  assign v_inc         = v_addr + (ppuctrl[2] ? VRAM_AW'(32) : VRAM_AW'(1));

  assign VRAM_addr     = {{(16-VRAM_AW){1'b0}}, v_addr};
  assign VRAM_wdata    = lat_data;
  assign palette_addr  = v_addr[4:0];
  assign palette_wdata = lat_data;
  assign VRAM_WE       = (state == S_XFER) & ~lat_rw & ~is_pal;
  assign palette_WE    = (state == S_XFER) & ~lat_rw & is_pal;

  // set beats both clear sources so a coincident status read cannot lose a new vblank
  assign vblank_nxt = vblank_start ? 1'b1 :
                      (vblank_end | status_rd) ? 1'b0 : vblank;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      v_addr       <= '0;
      toggle       <= 1'b0;
      vblank       <= 1'b0;
      lat_rw       <= 1'b0;
      lat_data     <= 8'h00;
      rd_buf       <= 8'h00;
      cpu_data_out <= 8'h00;
      ppuctrl      <= 8'h00;
      ppumask      <= 8'h00;
      scroll_x     <= 8'h00;
      scroll_y     <= 8'h00;
    end else begin
      vblank <= vblank_nxt;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (cpu_addr == 3'd7) begin
              lat_rw   <= cpu_rw;
              lat_data <= cpu_data_in;
              state    <= S_WAIT_BUS;
            end else if (cpu_rw) begin
              cpu_data_out <= (cpu_addr == 3'd2) ? {vblank, 7'b0} : 8'h00;
              if (cpu_addr == 3'd2) toggle <= 1'b0;
            end else begin
              case (cpu_addr)
                3'd0: ppuctrl <= cpu_data_in;
                3'd1: ppumask <= cpu_data_in;
                3'd5: begin
                  if (toggle) scroll_y <= cpu_data_in;
                  else        scroll_x <= cpu_data_in;
                  toggle <= ~toggle;
                end
                3'd6: begin
                  if (toggle) v_addr[7:0]         <= cpu_data_in;
                  else        v_addr[VRAM_AW-1:8] <= cpu_data_in[VRAM_AW-9:0];
                  toggle <= ~toggle;
                end
                default: ;
              endcase
            end
          end
        end
        S_WAIT_BUS: begin
          if (!render) state <= S_XFER;
        end
        S_XFER: begin
          if (lat_rw && !is_pal) begin
            state <= S_RD_CAP;
          end else begin
            if (lat_rw) cpu_data_out <= palette_rdata;
            v_addr <= v_inc;
            state  <= S_IDLE;
          end
        end
        S_RD_CAP: begin
          cpu_data_out <= rd_buf;
          rd_buf       <= VRAM_rdata;
          v_addr       <= v_inc;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PPU_NMI_EN
  logic ctrl7_nxt;
  assign ctrl7_nxt = (access & ~cpu_rw & (cpu_addr == 3'd0)) ? cpu_data_in[7] : ppuctrl[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nmi <= 1'b0;
    else        nmi <= vblank_nxt & ctrl7_nxt;
  end
`else
  assign nmi = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_cpu_reg_if.sv
// Directed self-checking bench for ppu_cpu_reg_if with behavioural VRAM and palette.
module tb_ppu_cpu_reg_if;

`ifdef PPU_NMI_EN
  localparam logic NMI_ON = 1'b1;
`else
  localparam logic NMI_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_rw;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_data_in, cpu_data_out;
  logic        cpu_ready, render, vblank_start, vblank_end;
  logic [15:0] VRAM_addr;
  logic        VRAM_WE;
  logic [7:0]  VRAM_wdata, VRAM_rdata;
  logic [4:0]  palette_addr;
  logic        palette_WE;
  logic [7:0]  palette_wdata, palette_rdata;
  logic [7:0]  ppuctrl, ppumask, scroll_x, scroll_y;
  logic        nmi;

  int checks = 0;
  int failures = 0;

  ppu_cpu_reg_if dut (
    .clk(clk), .reset(reset), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .render(render), .vblank_start(vblank_start), .vblank_end(vblank_end),
    .VRAM_addr(VRAM_addr), .VRAM_WE(VRAM_WE), .VRAM_wdata(VRAM_wdata), .VRAM_rdata(VRAM_rdata),
    .palette_addr(palette_addr), .palette_WE(palette_WE), .palette_wdata(palette_wdata),
    .palette_rdata(palette_rdata), .ppuctrl(ppuctrl), .ppumask(ppumask),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .nmi(nmi)
  );

  always #5 clk = ~clk;

  logic [7:0]  vram [0:16383];
  logic [7:0]  pal  [0:31];
  int          vram_we_cnt = 0;
  int          pal_we_cnt  = 0;
  logic [15:0] last_vaddr  = 16'h0;
  logic [7:0]  last_vdata  = 8'h0;
  logic [4:0]  last_paddr  = 5'h0;

  always @(posedge clk) begin
    if (VRAM_WE) begin
      vram[VRAM_addr[13:0]] = VRAM_wdata;
      vram_we_cnt++;
      last_vaddr = VRAM_addr;
      last_vdata = VRAM_wdata;
    end
    if (palette_WE) begin
      pal[palette_addr] = palette_wdata;
      pal_we_cnt++;
      last_paddr = palette_addr;
    end
    VRAM_rdata <= vram[VRAM_addr[13:0]];
  end

  assign palette_rdata = pal[palette_addr];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cpu_ready) check("ready_timeout", {15'b0, cpu_ready}, 16'h1);
  endtask

  task automatic acc(input logic rw, input logic [2:0] a, input logic [7:0] d);
    wait_ready();
    cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_data_in = d;
    @(posedge clk); #1;
    cpu_cs = 1'b0;
    if (a == 3'd7) wait_ready();
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    acc(1'b1, a, 8'h00);
    d = cpu_data_out;
  endtask

  task automatic pulse_vb(input logic s, input logic e);
    vblank_start = s; vblank_end = e;
    @(posedge clk); #1;
    vblank_start = 1'b0; vblank_end = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    logic       bad;
    int         cnt_before;
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    for (int i = 0; i < 32; i++) pal[i] = 8'h00;
    reset = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_addr = 3'd0; cpu_data_in = 8'h00;
    render = 1'b0; vblank_start = 1'b0; vblank_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {15'b0, cpu_ready}, 16'h1);
    check("rst_vram_we", {15'b0, VRAM_WE}, 16'h0);
    check("rst_pal_we", {15'b0, palette_WE}, 16'h0);
    check("rst_nmi", {15'b0, nmi}, 16'h0);
    check("rst_ppuctrl", {8'h0, ppuctrl}, 16'h0);
    check("rst_vaddr", VRAM_addr, 16'h0);
    check("rst_dout", {8'h0, cpu_data_out}, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // PPUADDR then single VRAM write
    acc(1'b0, 3'd6, 8'h21);
    check("ppuaddr_ready", {15'b0, cpu_ready}, 16'h1);
    acc(1'b0, 3'd6, 8'h08);
    acc(1'b0, 3'd7, 8'h5A);
    check("wr1_count", 16'(vram_we_cnt), 16'd1);
    check("wr1_addr", last_vaddr, 16'h2108);
    check("wr1_data", {8'h0, last_vdata}, 16'h005A);
    acc(1'b0, 3'd7, 8'h77);
    check("wr2_addr_inc", last_vaddr, 16'h2109);

    // shared toggle between PPUSCROLL and PPUADDR, status read resets it
    acc(1'b0, 3'd5, 8'h12);
    acc(1'b0, 3'd5, 8'h34);
    check("scroll_x", {8'h0, scroll_x}, 16'h0012);
    check("scroll_y", {8'h0, scroll_y}, 16'h0034);
    acc(1'b0, 3'd5, 8'h56);
    rd(3'd2, r);
    acc(1'b0, 3'd5, 8'h78);
    check("toggle_clr_x", {8'h0, scroll_x}, 16'h0078);
    acc(1'b0, 3'd5, 8'h9A);
    check("toggle_clr_y", {8'h0, scroll_y}, 16'h009A);

    // increment by 32
    acc(1'b0, 3'd0, 8'h04);
    acc(1'b0, 3'd6, 8'h20);
    acc(1'b0, 3'd6, 8'h00);
    acc(1'b0, 3'd7, 8'hAA);
    check("inc32_a", last_vaddr, 16'h2000);
    acc(1'b0, 3'd7, 8'hBB);
    check("inc32_b", last_vaddr, 16'h2020);
    acc(1'b0, 3'd7, 8'hCC);
    check("inc32_c", last_vaddr, 16'h2040);
    check("inc32_cnt", 16'(vram_we_cnt), 16'd5);

    // buffered reads
    acc(1'b0, 3'd0, 8'h00);
    vram[14'h0300] = 8'h11; vram[14'h0301] = 8'h22; vram[14'h0302] = 8'h33;
    acc(1'b0, 3'd6, 8'h03);
    acc(1'b0, 3'd6, 8'h00);
    rd(3'd7, r); check("bufrd_1", {8'h0, r}, 16'h0000);
    rd(3'd7, r); check("bufrd_2", {8'h0, r}, 16'h0011);
    rd(3'd7, r); check("bufrd_3", {8'h0, r}, 16'h0022);

    // palette write and direct read
    acc(1'b0, 3'd6, 8'h3F);
    acc(1'b0, 3'd6, 8'h10);
    acc(1'b0, 3'd7, 8'h0F);
    check("pal_we_cnt", 16'(pal_we_cnt), 16'd1);
    check("pal_addr", {11'h0, last_paddr}, 16'h0010);
    check("pal_no_vram", 16'(vram_we_cnt), 16'd5);
    acc(1'b0, 3'd6, 8'h3F);
    acc(1'b0, 3'd6, 8'h10);
    rd(3'd7, r); check("pal_rd", {8'h0, r}, 16'h000F);
    acc(1'b0, 3'd6, 8'h05);
    acc(1'b0, 3'd6, 8'h00);
    rd(3'd7, r); check("buf_kept", {8'h0, r}, 16'h0033);

    // render stall; an access during the stall must be dropped
    acc(1'b0, 3'd6, 8'h21);
    acc(1'b0, 3'd6, 8'h00);
    render = 1'b1;
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd7; cpu_data_in = 8'hE5;
    @(posedge clk); #1;
    cpu_cs = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd0; cpu_data_in = 8'hFF; end
      if (cpu_ready || VRAM_WE || palette_WE) bad = 1'b1;
      @(posedge clk); #1;
      cpu_cs = 1'b0;
    end
    check("stall_quiet", {15'b0, bad}, 16'h0);
    check("stall_drop", {8'h0, ppuctrl}, 16'h0000);
    check("stall_nocnt", 16'(vram_we_cnt), 16'd5);
    render = 1'b0;
    @(posedge clk); #1;
    check("stall_we", {15'b0, VRAM_WE}, 16'h1);
    check("stall_addr", VRAM_addr, 16'h2100);
    wait_ready();
    check("stall_cnt", 16'(vram_we_cnt), 16'd6);
    check("stall_data", {8'h0, last_vdata}, 16'h00E5);

    // vblank / nmi
    acc(1'b0, 3'd0, 8'h80);
    check("nmi_pre", {15'b0, nmi}, 16'h0);
    pulse_vb(1'b1, 1'b0);
    check("nmi_set", {15'b0, nmi}, {15'b0, NMI_ON});
    rd(3'd2, r); check("status_1", {8'h0, r}, 16'h0080);
    check("nmi_clr", {15'b0, nmi}, 16'h0);
    rd(3'd3, r); check("oam_rd", {8'h0, r}, 16'h0000);
    rd(3'd2, r); check("status_2", {8'h0, r}, 16'h0000);

    // coincident vblank_start and status read
    vblank_start = 1'b1;
    cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 3'd2;
    @(posedge clk); #1;
    cpu_cs = 1'b0; vblank_start = 1'b0;
    check("race_rd", {8'h0, cpu_data_out}, 16'h0000);
    rd(3'd2, r); check("race_flag", {8'h0, r}, 16'h0080);
    pulse_vb(1'b1, 1'b1);
    rd(3'd2, r); check("set_wins", {8'h0, r}, 16'h0080);
    pulse_vb(1'b1, 1'b0);
    pulse_vb(1'b0, 1'b1);
    rd(3'd2, r); check("vb_end", {8'h0, r}, 16'h0000);

    // enabling NMI while in vblank
    acc(1'b0, 3'd0, 8'h00);
    pulse_vb(1'b1, 1'b0);
    check("nmi_masked", {15'b0, nmi}, 16'h0);
    acc(1'b0, 3'd0, 8'h80);
    check("nmi_late_en", {15'b0, nmi}, {15'b0, NMI_ON});
    rd(3'd2, r);

    // reset mid-transfer aborts with no strobe
    cnt_before = vram_we_cnt;
    render = 1'b1;
    acc(1'b0, 3'd0, 8'h00);
    cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd7; cpu_data_in = 8'h99;
    @(posedge clk); #1;
    cpu_cs = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_ready", {15'b0, cpu_ready}, 16'h1);
    render = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_nowe", 16'(vram_we_cnt), 16'(cnt_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_cpu_reg_if.md
Name: ppu_cpu_reg_if

Overview:
- CPU-facing PPU register file at $2000-$2007. It is the writer/initiator side of the VRAM and palette ports that the renderer only reads.
- Decodes CPU register accesses, keeps the PPUADDR/PPUSCROLL write toggle, and runs the buffered PPUDATA read path.
- Issues VRAM/palette read and write cycles, but only while the renderer is idle (render low).
- Owns the vblank flag and the NMI request.

Parameters:
- VRAM_AW, 14, effective PPU address width; upper bits of the 16-bit VRAM_addr are driven 0.

Ports:
- clk  in  1  system clock (same as the renderer)
- reset  in  1  asynchronous, active-low reset
- cpu_cs  in  1  one-cycle access strobe; sampled only when cpu_ready=1
- cpu_rw  in  1  1=read, 0=write
- cpu_addr  in  3  register select ($2000+n)
- cpu_data_in  in  8  write data
- cpu_data_out  out  8  read data; valid in the cycle cpu_ready rises after a read
- cpu_ready  out  1  1=idle and able to accept an access
- render  in  1  renderer owns VRAM while 1
- vblank_start  in  1  one-cycle pulse at the start of vblank
- vblank_end  in  1  one-cycle pulse at the pre-render line
- VRAM_addr  out  16  VRAM address
- VRAM_WE  out  1  VRAM write enable
- VRAM_wdata  out  8  to VRAM data_in
- VRAM_rdata  in  8  from VRAM data_out; one-cycle synchronous latency
- palette_addr  out  5  palette index
- palette_WE  out  1  palette write enable
- palette_wdata  out  8  palette write data
- palette_rdata  in  8  palette read data; combinational
- ppuctrl  out  8  PPUCTRL register
- ppumask  out  8  PPUMASK register
- scroll_x  out  8  horizontal scroll
- scroll_y  out  8  vertical scroll
- nmi  out  1  active-high NMI request

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, the toggle, the read buffer, the vblank flag and v_addr clear to 0
  - VRAM_WE=0, palette_WE=0, nmi=0, cpu_ready=1, state=IDLE.
- Accesses are accepted only when cpu_ready=1 and cpu_cs=1. cpu_ready drops in the next cycle for PPUDATA accesses only; every other register completes in one cycle with cpu_ready held high.
- Register map:
  - 0 PPUCTRL (W).
  - 1 PPUMASK (W).
  - 2 PPUSTATUS (R): returns {vblank,7'b0}. The read clears vblank and the toggle in the same edge.
  - 3, 4 (OAM): writes ignored, reads return 0.
  - 5 PPUSCROLL (W): toggle=0 writes scroll_x, toggle=1 writes scroll_y; the toggle then flips.
  - 6 PPUADDR (W): toggle=0 loads v_addr[13:8]=data[5:0] (v_addr[14+] ignored); toggle=1 loads v_addr[7:0]; the toggle then flips. PPUADDR and PPUSCROLL share one toggle.
  - 7 PPUDATA (R/W): drives the state machine below.
- Increment: after each PPUDATA access, v_addr += (ppuctrl[2] ? 32 : 1), modulo 2^14 (wraps $3FFF -> $0000 or $001F).
- Palette region: v_addr[13:8]==6'h3F. Palette_addr=v_addr[4:0]. Such accesses never touch VRAM.
- FSM states: IDLE, WAIT_BUS, XFER, RD_CAP.
  - IDLE: a PPUDATA access latches cpu_rw and the data, and the block goes to WAIT_BUS.
  - WAIT_BUS: the block stays while render=1 (a stall of any length). At render=0 it goes to XFER.
  - XFER, write: pulse VRAM_WE or palette_WE for exactly one cycle with VRAM_addr=v_addr, then increment and return to IDLE.
  - XFER, VRAM read: present the address, go to RD_CAP.
  - XFER, palette read: cpu_data_out=palette_rdata, the read buffer is unchanged, increment, return to IDLE.
  - RD_CAP: cpu_data_out=old read buffer, read buffer<=VRAM_rdata, increment, return to IDLE. This models the one-read delay of PPUDATA.
  - If render rises while in XFER or RD_CAP, the transfer still completes; the renderer must not begin before the following cycle.
- cpu_ready=1 only in IDLE. An access arriving while cpu_ready=0 is ignored and not queued.
- vblank flag:
  - set on vblank_start, cleared on vblank_end or on a PPUSTATUS read
  - if vblank_start and a PPUSTATUS read occur in the same cycle: the read returns 0 and the flag ends set
  - if vblank_end and vblank_start occur together: the set wins.
- A mid-operation reset aborts any transfer with no write strobe issued.

Optional Feature:
- PPU_NMI_EN defined:
  - nmi = vblank & ppuctrl[7], registered
  - a PPUCTRL write that sets bit 7 while vblank=1 raises nmi in the next cycle.
- PPU_NMI_EN undefined: nmi is tied to 0 and ppuctrl[7] is stored but has no effect.

Test Plan:
- Write $2006=$21, $2006=$08, then $2007=$5A with render=0 -> exactly one VRAM_WE pulse with VRAM_addr=$2108 and VRAM_wdata=$5A; v_addr=$2109.
- Set ppuctrl=$04, v_addr=$2000, write $2007 three times -> writes land at $2000, $2020, $2040.
- v_addr=$0300 with VRAM[$0300]=$11 and [$0301]=$22, read $2007 twice -> returns old buffer, then $11; buffer ends holding $22.
- v_addr=$3F10, write $2007=$0F, then read back from $3F10 -> palette_WE pulse with palette_addr=$10; the read returns $0F directly and VRAM_WE stays 0.
- Hold render=1 for 50 cycles during a $2007 write -> cpu_ready=0 throughout, no strobe appears; the strobe comes one cycle after render falls.
- Pulse vblank_start with ppuctrl=$80 -> nmi=1 (with PPU_NMI_EN). A $2002 read then returns $80; a second read returns $00 and nmi=0.
